frame_scheduler: RTL and testbench
==================================

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of command channels (legal 1..8).
REQ-002 SHALL have parameter REFRESH, default 1024, clock cycles between automatic resends of all enabled channels.
REQ-003 SHALL have parameter TIMEOUT, default 4096, cycles to wait for tx_ready before abandoning a byte.
REQ-004 SHALL have parameter PRIO_MODE, default 0, where 0 = round-robin and 1 = fixed priority with the lowest index winning.
REQ-005 SHALL have port clock  in  1  UART clock (16x baud), the single clock.
REQ-006 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-007 SHALL have port ch_data  in  NCH*8  packed channel bytes; channel i occupies [8i+7:8i].
REQ-008 SHALL have port ch_en  in  NCH  per-channel enable (level).
REQ-009 SHALL have port force_refresh  in  1  single-cycle pulse that marks every channel stale.
REQ-010 SHALL have port tx_ready  in  1  single-cycle pulse from UART after a byte is transmitted.
REQ-011 SHALL have port tx_bits  out  8  byte presented to the UART dataIn port.
REQ-012 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-013 SHALL have port cur_ch  out  3  index of the channel being sent; holds its last value in IDLE.
REQ-014 SHALL have port timeout_cnt  out  8  saturating count of abandoned bytes.

Function
REQ-015 SHALL implement a 4-state FSM with states IDLE, LOAD, WAIT_READY and GAP.
REQ-016 SHALL set pending[i] = ch_en[i] AND (ch_data[i] != last_sent[i] OR stale[i]).
REQ-017 IDLE SHALL go to LOAD on the next edge when any pending bit is set, capturing the winner in cur_ch.
REQ-018 Winner selection:
- PRIO_MODE=0: first pending index at or after rr_ptr, wrapping modulo NCH.
- PRIO_MODE=1: lowest pending index.
REQ-019 LOAD SHALL snapshot ch_data[cur_ch] into a send register, drive it on tx_bits, and go to WAIT_READY next cycle (1 cycle).
REQ-020 WAIT_READY SHALL hold tx_bits stable and increment a wait counter each cycle.
REQ-021 On tx_ready in WAIT_READY:
- last_sent[cur_ch] <= snapshot.
- stale[cur_ch] <= 0.
- rr_ptr <= (cur_ch+1) mod NCH.
- Go to GAP.
REQ-022 On a timeout, when the wait counter reaches TIMEOUT-1 with no tx_ready:
- timeout_cnt increments, saturating at 255.
- last_sent and stale are left unchanged.
- rr_ptr advances as in REQ-021.
- Go to IDLE.
REQ-023 If tx_ready and the timeout coincide in the same cycle, the transfer SHALL be treated as a success.
REQ-024 GAP SHALL last exactly 1 cycle, drive tx_bits = 8'h00, and return to IDLE.
REQ-025 tx_bits SHALL be 8'h00 (the no-op byte) in IDLE and GAP.
REQ-026 tx_ready SHALL be ignored in IDLE, LOAD and GAP.
REQ-027 A refresh counter SHALL run 0..REFRESH-1 continuously; on wrap it sets all stale bits.
REQ-028 force_refresh SHALL set all stale bits.
REQ-029 When a stale set (REQ-027/REQ-028) coincides with a REQ-021 clear of the same channel, the set SHALL win.
REQ-030 ch_data changing during WAIT_READY SHALL NOT alter tx_bits; the new value becomes pending after completion.
REQ-031 ch_en deasserting during WAIT_READY SHALL NOT abort the transfer.
REQ-032 Minimum back-to-back spacing SHALL be LOAD+WAIT_READY+GAP+IDLE, i.e. 3 cycles plus the ready latency.

Reset
REQ-033 When reset_n=0 at a clock edge, the block SHALL enter IDLE and set:
- tx_bits=0, busy=0, cur_ch=0, timeout_cnt=0.
- rr_ptr=0, refresh counter=0, wait counter=0.
- last_sent[*]=0, stale[*]=1.
REQ-034 Reset asserted mid-WAIT_READY SHALL abandon the byte without incrementing timeout_cnt.

Verification
REQ-035 Reset, then ch_en=4'b0001, ch0=8'h05, tx_ready 10 cycles after LOAD -> tx_bits=8'h05 for 11 cycles, then GAP 8'h00, then idle with busy=0 and no resend.
REQ-036 PRIO_MODE=0, all 4 channels pending, immediate tx_ready each time -> cur_ch sequence 0,1,2,3; then change ch1 and ch3 -> order 1,3.
REQ-037 PRIO_MODE=1, ch2 and ch3 pending, ch0 becomes pending while ch2 is in WAIT_READY -> order 2,0,3.
REQ-038 TIMEOUT=16, tx_ready never pulsed -> return to IDLE after 16 WAIT_READY cycles, timeout_cnt=1, same byte retried; after 300 timeouts timeout_cnt=255.
REQ-039 REFRESH=64, static data on 2 enabled channels -> both resent once per 64-cycle wrap; force_refresh pulse -> immediate resend of both.
REQ-040 tx_ready and timeout in the same cycle -> timeout_cnt unchanged and no resend; reset_n=0 mid-WAIT_READY -> outputs at reset values on the next cycle.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler: picks changed or stale command channels and feeds
// their bytes one at a time to a UART transmitter with a timeout.
module frame_scheduler #(
    parameter int NCH       = 4,
    parameter int REFRESH   = 1024,
    parameter int TIMEOUT   = 4096,
    parameter int PRIO_MODE = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NCH*8-1:0] ch_data,
    input  logic [NCH-1:0]   ch_en,
    input  logic             force_refresh,
    input  logic             tx_ready,
    output logic [7:0]       tx_bits,
    output logic             busy,
    output logic [2:0]       cur_ch,
    output logic [7:0]       timeout_cnt
);

    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_READY,
        GAP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [7:0]      last_sent [NCH];
    logic [NCH-1:0]  stale;
    logic [NCH-1:0]  pending;
    logic [7:0]      snap;
    logic [7:0]      cur_byte;
    logic [2:0]      rr_ptr;
    logic [2:0]      next_ptr;
    logic [2:0]      win;
    logic            any_pend;
    logic [RW-1:0]   ref_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            refresh_wrap;
    logic            timeout_hit;
    logic            done;
    logic            tmo;

    assign any_pend     = |pending;
    assign refresh_wrap = (ref_cnt == RW'(REFRESH - 1));
    assign timeout_hit  = (wait_cnt == TW'(TIMEOUT - 1));
    assign done         = (state == WAIT_READY) && tx_ready;
    assign tmo          = (state == WAIT_READY) && !tx_ready && timeout_hit;
    assign next_ptr     = (cur_ch == 3'(NCH - 1)) ? 3'd0 : cur_ch + 3'd1;
    assign busy         = (state != IDLE);

    // A channel needs sending when enabled and either changed or stale
    always_comb begin
        pending = '0;
        for (int i = 0; i < NCH; i++) begin
            pending[i] = ch_en[i] &&
                ((ch_data[8*i +: 8] != last_sent[i]) || stale[i]);
        end
    end

    // Winner: lowest index, or first index at/after rr_ptr (scan backwards so the nearest wins)
    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (pending[i]) win = 3'(i);
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (pending[idx]) win = 3'(idx);
            end
        end
    end

    // Byte of the channel currently selected
    always_comb begin
        cur_byte = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch == 3'(i)) cur_byte = ch_data[8*i +: 8];
        end
    end

    // Next-state and tx_bits; the no-op byte outside LOAD/WAIT_READY
    always_comb begin
        state_nx = state;
        tx_bits  = 8'h00;
        unique case (state)
            IDLE: begin
                if (any_pend) state_nx = LOAD;
            end
            LOAD: begin
                tx_bits  = cur_byte;
                state_nx = WAIT_READY;
            end
            WAIT_READY: begin
                tx_bits = snap;
                if (tx_ready) state_nx = GAP;
                else if (timeout_hit) state_nx = IDLE;
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // Channel select, snapshot, wait timer, arbitration pointer, timeout count
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cur_ch      <= '0;
            snap        <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            if (state == IDLE && any_pend) cur_ch <= win;
            if (state == LOAD) begin
                snap     <= cur_byte;
                wait_cnt <= '0;
            end
            if (state == WAIT_READY) wait_cnt <= wait_cnt + 1'b1;
            if (done || tmo) rr_ptr <= next_ptr;
            if (tmo && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

    // Sent-history, stale flags and refresh timer; a refresh set beats a completion clear
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) last_sent[i] <= '0;
            stale   <= '1;
            ref_cnt <= '0;
        end else begin
            ref_cnt <= refresh_wrap ? '0 : ref_cnt + 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (done && cur_ch == 3'(i)) begin
                    last_sent[i] <= snap;
                    stale[i]     <= 1'b0;
                end
            end
            if (refresh_wrap || force_refresh) stale <= '1;
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: three instances with different
// parameters share stimulus; the ones not under test are held in reset.
module tb_frame_scheduler;

    logic        clock = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic [31:0] ch_data;
    logic [3:0]  ch_en;
    logic        force_refresh;
    logic        tx_ready;

    logic [7:0] tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] cur_a, cur_b, cur_c;
    logic [7:0] tmo_a, tmo_b, tmo_c;

    int errors = 0;
    int checks = 0;
    int order[$];

    always #5 clock = ~clock;

    frame_scheduler #(.NCH(4), .REFRESH(1024), .TIMEOUT(4096), .PRIO_MODE(0)) u_a (
        .clock(clock), .reset_n(rst_a), .ch_data(ch_data), .ch_en(ch_en),
        .force_refresh(force_refresh), .tx_ready(tx_ready), .tx_bits(tx_a),
        .busy(busy_a), .cur_ch(cur_a), .timeout_cnt(tmo_a)
    );

    frame_scheduler #(.NCH(4), .REFRESH(1024), .TIMEOUT(4096), .PRIO_MODE(1)) u_b (
        .clock(clock), .reset_n(rst_b), .ch_data(ch_data), .ch_en(ch_en),
        .force_refresh(force_refresh), .tx_ready(tx_ready), .tx_bits(tx_b),
        .busy(busy_b), .cur_ch(cur_b), .timeout_cnt(tmo_b)
    );

    frame_scheduler #(.NCH(4), .REFRESH(64), .TIMEOUT(16), .PRIO_MODE(0)) u_c (
        .clock(clock), .reset_n(rst_c), .ch_data(ch_data), .ch_en(ch_en),
        .force_refresh(force_refresh), .tx_ready(tx_ready), .tx_bits(tx_c),
        .busy(busy_c), .cur_ch(cur_c), .timeout_cnt(tmo_c)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [7:0] v);
        ch_data[8*i +: 8] = v;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic [2:0] get_cur(input int sel);
        return (sel == 0) ? cur_a : (sel == 1) ? cur_b : cur_c;
    endfunction

    // Record cur_ch each time the selected instance leaves IDLE
    task automatic collect(input int sel, input int cycles);
        logic prev;
        order.delete();
        prev = get_busy(sel);
        repeat (cycles) begin
            step(1);
            if (get_busy(sel) && !prev) order.push_back(int'(get_cur(sel)));
            prev = get_busy(sel);
        end
    endtask

    function automatic int ord(input int k);
        return (k < order.size()) ? order[k] : 99;
    endfunction

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        ch_data = '0;
        ch_en = '0;
        force_refresh = 1'b0;
        tx_ready = 1'b0;
        step(2);

        chk("rst_busy_a", busy_a, 0);
        chk("rst_tx_a", tx_a, 8'h00);
        chk("rst_cur_a", cur_a, 0);
        chk("rst_tmo_a", tmo_a, 0);
        chk("rst_busy_c", busy_c, 0);
        chk("rst_tmo_c", tmo_c, 0);

        // Single channel, ready ten cycles into WAIT_READY
        ch_en = 4'b0001;
        set_ch(0, 8'h05);
        rst_a = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step(1);
            chk("a_tx_hold", tx_a, 8'h05);
            if (i == 1) chk("a_busy_load", busy_a, 1);
            if (i == 11) tx_ready = 1'b1;
        end
        step(1);
        tx_ready = 1'b0;
        chk("a_gap_tx", tx_a, 8'h00);
        chk("a_gap_busy", busy_a, 1);
        step(1);
        chk("a_idle_busy", busy_a, 0);
        collect(0, 20);
        chk("a_noresend", order.size(), 0);

        // Round robin over four channels, then only changed ones
        rst_a = 1'b0;
        ch_en = 4'b1111;
        ch_data = 32'h04030201;
        step(2);
        rst_a = 1'b1;
        tx_ready = 1'b1;
        collect(0, 24);
        chk("rr_n", order.size(), 4);
        chk("rr_0", ord(0), 0);
        chk("rr_1", ord(1), 1);
        chk("rr_2", ord(2), 2);
        chk("rr_3", ord(3), 3);
        set_ch(1, 8'h11);
        set_ch(3, 8'h33);
        collect(0, 16);
        chk("rr2_n", order.size(), 2);
        chk("rr2_0", ord(0), 1);
        chk("rr2_1", ord(1), 3);
        tx_ready = 1'b0;

        // Data change and disable during WAIT_READY
        set_ch(2, 8'h77);
        step(1);
        chk("d_cur", cur_a, 2);
        chk("d_tx_load", tx_a, 8'h77);
        step(1);
        set_ch(2, 8'h88);
        ch_en = 4'b1011;
        step(3);
        chk("d_tx_stable", tx_a, 8'h77);
        chk("d_no_abort", busy_a, 1);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        chk("d_gap_tx", tx_a, 8'h00);
        chk("d_gap_busy", busy_a, 1);
        step(1);
        chk("d_idle", busy_a, 0);
        step(3);
        chk("d_disabled", busy_a, 0);
        ch_en = 4'b1111;
        step(1);
        chk("d_resend_busy", busy_a, 1);
        chk("d_resend_cur", cur_a, 2);
        chk("d_resend_tx", tx_a, 8'h88);
        rst_a = 1'b0;

        // Fixed priority: ch0 arrives while ch2 is waiting
        ch_en = 4'b1100;
        set_ch(0, 8'h10);
        set_ch(2, 8'h22);
        set_ch(3, 8'h33);
        tx_ready = 1'b0;
        step(1);
        rst_b = 1'b1;
        step(1);
        chk("p_first", cur_b, 2);
        step(1);
        ch_en = 4'b1101;
        step(3);
        chk("p_wait_busy", busy_b, 1);
        chk("p_wait_cur", cur_b, 2);
        tx_ready = 1'b1;
        collect(1, 20);
        chk("p_n", order.size(), 2);
        chk("p_0", ord(0), 0);
        chk("p_1", ord(1), 3);
        tx_ready = 1'b0;
        rst_b = 1'b0;

        // Timeouts with no ready, retry, saturation
        ch_en = 4'b0001;
        set_ch(0, 8'h5A);
        rst_c = 1'b1;
        step(17);
        chk("t_last_wait", busy_c, 1);
        chk("t_cnt0", tmo_c, 0);
        step(1);
        chk("t_idle", busy_c, 0);
        chk("t_cnt1", tmo_c, 1);
        step(1);
        chk("t_retry_busy", busy_c, 1);
        chk("t_retry_cur", cur_c, 0);
        chk("t_retry_tx", tx_c, 8'h5A);
        step(5600);
        chk("t_sat", tmo_c, 8'hFF);
        rst_c = 1'b0;
        step(1);

        // Periodic refresh then forced refresh
        ch_en = 4'b0011;
        set_ch(0, 8'hA1);
        set_ch(1, 8'hB2);
        tx_ready = 1'b1;
        step(1);
        rst_c = 1'b1;
        collect(2, 150);
        chk("r_n", order.size(), 6);
        chk("r_2", ord(2), 0);
        chk("r_5", ord(5), 1);
        force_refresh = 1'b1;
        step(1);
        force_refresh = 1'b0;
        collect(2, 30);
        chk("f_n", order.size(), 2);
        chk("f_0", ord(0), 0);
        chk("f_1", ord(1), 1);

        // Ready on the timeout cycle counts as success
        rst_c = 1'b0;
        ch_en = 4'b0001;
        set_ch(0, 8'hC3);
        tx_ready = 1'b0;
        step(1);
        rst_c = 1'b1;
        step(17);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        chk("g_gap_busy", busy_c, 1);
        chk("g_gap_tx", tx_c, 8'h00);
        chk("g_tmo", tmo_c, 0);
        step(1);
        chk("g_idle", busy_c, 0);
        collect(2, 10);
        chk("g_noresend", order.size(), 0);
        chk("g_tmo_after", tmo_c, 0);

        // Refresh coinciding with completion keeps the channel stale
        ch_en = 4'b0100;
        set_ch(2, 8'hE5);
        step(1);
        chk("h_cur", cur_c, 2);
        step(1);
        tx_ready = 1'b1;
        force_refresh = 1'b1;
        step(1);
        tx_ready = 1'b0;
        force_refresh = 1'b0;
        step(2);
        chk("h_resend_busy", busy_c, 1);
        chk("h_resend_cur", cur_c, 2);

        // Reset in the middle of WAIT_READY
        step(2);
        chk("h_wait_busy", busy_c, 1);
        rst_c = 1'b0;
        step(1);
        chk("x_busy", busy_c, 0);
        chk("x_tx", tx_c, 8'h00);
        chk("x_cur", cur_c, 0);
        chk("x_tmo", tmo_c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
